// File: rtl/tlc_pkg.sv
// Traffic-light sequencer shared definitions: lamp encodings, FSM state
// type and lamp decode helpers. Optional feature macro: TLC_PED_WALK_EN
// (adds the pedestrian-walk state PW).
package tlc_pkg;

   typedef logic [1:0] lamp_t;

   localparam lamp_t GREEN  = 2'd0;
   localparam lamp_t YELLOW = 2'd1;
   localparam lamp_t RED    = 2'd2;

`ifdef TLC_PED_WALK_EN
   typedef enum logic [2:0] {
      HG = 3'd0,
      HY = 3'd1,
      FG = 3'd2,
      FY = 3'd3,
      PW = 3'd4
   } tlc_state_t;
`else
   typedef enum logic [2:0] {
      HG = 3'd0,
      HY = 3'd1,
      FG = 3'd2,
      FY = 3'd3
   } tlc_state_t;
`endif

   // Highway lamp for a state; anything unexpected shows RED.
   function automatic lamp_t hwy_lamp(tlc_state_t s);
      case (s)
         HG:      return GREEN;
         HY:      return YELLOW;
         default: return RED;
      endcase
   endfunction

   // Farm-road lamp for a state; anything unexpected shows RED.
   function automatic lamp_t farm_lamp(tlc_state_t s);
      case (s)
         FG:      return GREEN;
         FY:      return YELLOW;
         default: return RED;
      endcase
   endfunction

endpackage

// File: rtl/tlc_if.sv
// Sequencer <-> environment signal bundle (sensors, interval timer, lamps).
// Optional feature macro: TLC_PED_WALK_EN (adds ped/walk).
//
// Timer handshake: st is a one-cycle restart pulse from the sequencer; the
// external timer restarts on it and raises ts (short) / tl (long) as levels
// afterwards. The sequencer treats ts/tl as stale while st is high.
interface tlc_if;
   import tlc_pkg::*;

   logic  car;
   logic  ts;
   logic  tl;
   logic  st;
   lamp_t hwy;
   lamp_t farm;
`ifdef TLC_PED_WALK_EN
   logic  ped;
   logic  walk;

   modport master (input car, ts, tl, ped, output st, hwy, farm, walk);
   modport slave  (output car, ts, tl, ped, input st, hwy, farm, walk);
`else
   modport master (input car, ts, tl, output st, hwy, farm);
   modport slave  (output car, ts, tl, input st, hwy, farm);
`endif

endinterface

// File: rtl/tlc_sync.sv
// STAGES-deep synchroniser for one asynchronous level input, cleared by
// the asynchronous active-low reset.
module tlc_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/tlc_sequencer.sv
// Highway / farm-road traffic-light sequencer driven by an external
// interval timer. Optional feature macro: TLC_PED_WALK_EN (pedestrian
// request latch and all-red walk phase PW).
module tlc_sequencer
   import tlc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   tlc_if.master      bus,
   output tlc_state_t state_dbg
);

   logic       car_s;
   tlc_state_t state_q;
   tlc_state_t state_d;
   logic       started_q;
   logic       st_q;
   lamp_t      hwy_q;
   lamp_t      farm_q;
   logic       timer_stale;

   tlc_sync #(.STAGES(SYNC_STAGES)) u_sync_car (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.car),
      .q     (car_s)
   );

`ifdef TLC_PED_WALK_EN
   logic ped_s;
   logic ped_req;
   logic walk_q;

   tlc_sync #(.STAGES(SYNC_STAGES)) u_sync_ped (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.ped),
      .q     (ped_s)
   );

   // Sticky pedestrian request; consumed when the walk phase ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_req <= 1'b0;
      end else if (state_q == PW && state_d == HG) begin
         ped_req <= ped_s;
      end else if (ped_s) begin
         ped_req <= 1'b1;
      end
   end
`endif

   // Timer flags are meaningless in the restart cycle and before the very
   // first restart after reset.
   assign timer_stale = st_q | ~started_q;

   // Next-state decision; illegal encodings fall back to HG.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HG: if (!timer_stale && car_s && bus.tl) state_d = HY;
`ifdef TLC_PED_WALK_EN
         HY: if (!timer_stale && bus.ts) state_d = (ped_req && !car_s) ? PW : FG;
`else
         HY: if (!timer_stale && bus.ts) state_d = FG;
`endif
         FG: if (!timer_stale && (!car_s || bus.tl)) state_d = FY;
`ifdef TLC_PED_WALK_EN
         FY: if (!timer_stale && bus.ts) state_d = ped_req ? PW : HG;
         PW: if (!timer_stale && bus.tl) state_d = HG;
`else
         FY: if (!timer_stale && bus.ts) state_d = HG;
`endif
         default: state_d = HG;
      endcase
   end

   // State, restart pulse and lamps all update on the same edge so the
   // lamps change in the cycle st is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HG;
         started_q <= 1'b0;
         st_q      <= 1'b0;
         hwy_q     <= GREEN;
         farm_q    <= RED;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
         st_q      <= (state_d != state_q) || !started_q;
         hwy_q     <= hwy_lamp(state_d);
         farm_q    <= farm_lamp(state_d);
      end
   end

`ifdef TLC_PED_WALK_EN
   // Walk lamp is lit only in the all-red pedestrian phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         walk_q <= 1'b0;
      end else begin
         walk_q <= (state_d == PW);
      end
   end

   assign bus.walk = walk_q;
`endif

   assign bus.st    = st_q;
   assign bus.hwy   = hwy_q;
   assign bus.farm  = farm_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_tlc_sequencer.sv
// Bench for tlc_sequencer with a behavioural interval timer. Optional
// feature macro: TLC_PED_WALK_EN (enables the pedestrian sequence).
`timescale 1ns/1ps
module tb_tlc_sequencer;
  import tlc_pkg::*;

  localparam int SS = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlc_if bus();
  tlc_state_t state_dbg;

  tlc_sequencer #(.SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- interval timer model ----------------
  int   tmr_cnt = 0;
  logic force_t = 1'b0;
  initial forever begin
    @(negedge clk);
    if (bus.st === 1'b1) tmr_cnt = 1;
    else if (tmr_cnt < 1000) tmr_cnt++;
  end
  assign bus.ts = force_t | (tmr_cnt >= 5);
  assign bus.tl = force_t | (tmr_cnt >= 15);

  logic walk_o;
`ifdef TLC_PED_WALK_EN
  assign walk_o = bus.walk;
`else
  assign walk_o = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    lamp_t       hwy;
    lamp_t       farm;
    logic        walk;
  } ev_t;

  ev_t        exp_q[$];
  logic [4:0] cur_exp;
  logic [5:0] mon_act;
  logic [5:0] mon_req;
  logic       mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic void push_ev(input int t, input lamp_t h, input lamp_t f, input logic w);
    ev_t e;
    e.cyc  = t;
    e.hwy  = h;
    e.farm = f;
    e.walk = w;
    exp_q.push_back(e);
  endfunction

  // Every cycle: either an expected phase change (st with new lamps) or a
  // quiet cycle holding the current lamps; plus the two-road safety rule.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_phase", 32'(cyc), exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        cur_exp = {exp_q[0].hwy, exp_q[0].farm, exp_q[0].walk};
        mon_req = {1'b1, cur_exp};
        void'(exp_q.pop_front());
      end else begin
        mon_req = {1'b0, cur_exp};
      end
      mon_act = {bus.st, bus.hwy, bus.farm, walk_o};
      check("st_lamps", 32'(mon_act), 32'(mon_req));
      check("one_road_red", 32'((bus.hwy == RED) || (bus.farm == RED)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hwy"},   32'(bus.hwy),  32'(GREEN));
    check({tag, "_farm"},  32'(bus.farm), 32'(RED));
    check({tag, "_st"},    32'(bus.st),   32'd0);
    check({tag, "_walk"},  32'(walk_o),   32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(HG));
  endtask

  typedef struct {
    logic  car;
    lamp_t hwy;
    lamp_t farm;
    int    dur;
  } vec_t;

  vec_t vecs[8];
  int   tev[8];

  initial begin
    int t;
    int c;
    bus.car = 1'b0;
`ifdef TLC_PED_WALK_EN
    bus.ped = 1'b0;
`endif
    cur_exp = {GREEN, RED, 1'b0};
    repeat (3) @(negedge clk);
    check_reset("in_reset");

    // Release: one restart pulse, then HG held with no car.
    push_ev(cyc + 1, GREEN, RED, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_until(cyc + 100);

    // Full cycle with car held: {car, lamps after change, cycles since previous change}.
    vecs = '{
      '{1'b1, YELLOW, RED,    SS + 1},
      '{1'b1, RED,    GREEN,  5},
      '{1'b1, RED,    YELLOW, 15},
      '{1'b1, GREEN,  RED,    5},
      '{1'b1, YELLOW, RED,    15},
      '{1'b1, RED,    GREEN,  5},
      '{1'b1, RED,    YELLOW, 15},
      '{1'b1, GREEN,  RED,    5}
    };
    t = cyc;
    for (int i = 0; i < 8; i++) begin
      t += vecs[i].dur;
      tev[i] = t;
      push_ev(t, vecs[i].hwy, vecs[i].farm, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      bus.car = vecs[i].car;
      wait_until(tev[i]);
    end

    // Car leaves 3 cycles into FG: FG ends early, then back to HG.
    t = cyc;
    push_ev(t + 15, YELLOW, RED, 1'b0);
    push_ev(t + 20, RED, GREEN, 1'b0);
    push_ev(t + 20 + 3 + SS + 1, RED, YELLOW, 1'b0);
    push_ev(t + 20 + 3 + SS + 1 + 5, GREEN, RED, 1'b0);
    wait_until(t + 23);
    bus.car = 1'b0;
    wait_until(t + 29 + SS + 20);

    // Timer flags forced high: each restart cycle must be skipped.
    c = cyc;
    force_t = 1'b1;
    bus.car = 1'b1;
    push_ev(c + SS + 1, YELLOW, RED, 1'b0);
    push_ev(c + SS + 3, RED, GREEN, 1'b0);
    push_ev(c + SS + 5, RED, YELLOW, 1'b0);
    push_ev(c + SS + 7, GREEN, RED, 1'b0);
    wait_until(c + SS + 1);
    bus.car = 1'b0;
    wait_until(c + SS + 7);
    force_t = 1'b0;
    wait_until(c + SS + 27);

    // Car leaves during HY: FG still follows, then ends at once.
    c = cyc;
    bus.car = 1'b1;
    push_ev(c + SS + 1, YELLOW, RED, 1'b0);
    push_ev(c + SS + 6, RED, GREEN, 1'b0);
    push_ev(c + SS + 8, RED, YELLOW, 1'b0);
    push_ev(c + SS + 13, GREEN, RED, 1'b0);
    wait_until(c + SS + 1);
    bus.car = 1'b0;
    wait_until(c + SS + 33);

    // Reset pulsed during FG: lamps return to HG immediately.
    c = cyc;
    bus.car = 1'b1;
    push_ev(c + SS + 1, YELLOW, RED, 1'b0);
    push_ev(c + SS + 6, RED, GREEN, 1'b0);
    wait_until(c + SS + 8);
    check("fg_before_reset", 32'(state_dbg), 32'(FG));
    rst_n = 1'b0;
    bus.car = 1'b0;
    #1;
    check_reset("mid_reset");
    repeat (2) @(negedge clk);
    check_reset("mid_reset_hold");
    cur_exp = {GREEN, RED, 1'b0};
    push_ev(cyc + 1, GREEN, RED, 1'b0);
    rst_n = 1'b1;
    wait_until(cyc + 25);

`ifdef TLC_PED_WALK_EN
    // One-cycle pedestrian press during HG with a car waiting.
    c = cyc;
    bus.car = 1'b1;
    bus.ped = 1'b1;
    push_ev(c + SS + 1,  YELLOW, RED,    1'b0);
    push_ev(c + SS + 6,  RED,    GREEN,  1'b0);
    push_ev(c + SS + 21, RED,    YELLOW, 1'b0);
    push_ev(c + SS + 26, RED,    RED,    1'b1);
    push_ev(c + SS + 41, GREEN,  RED,    1'b0);
    @(negedge clk);
    bus.ped = 1'b0;
    wait_until(c + SS + 28);
    bus.car = 1'b0;
    wait_until(c + SS + 61);
`endif

    check("phases_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
